// File: rtl/fixed_point_add_arbiter_pkg.sv
// Shared fixed-point types, limits and the adder datapath used by the
// arbitrated add unit (and reusable by other fixed-point arbiters).
package fixed_point_add_arbiter_pkg;

  localparam int FIXED_POINT_W = 32;

  // 32-bit two's-complement fixed-point word.
  typedef logic signed [FIXED_POINT_W-1:0] fixed_point_t;

  localparam fixed_point_t FIXED_POINT_MAX = 32'sh7FFF_FFFF;
  localparam fixed_point_t FIXED_POINT_MIN = 32'sh8000_0000;

  // Raw adder output: wrapped sum plus the signed-overflow flag.
  typedef struct packed {
    fixed_point_t sum;
    logic         overflow;
  } add_result_t;

  // Output register occupancy.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Two's-complement add; overflow when both operands share a sign and the
  // sum's sign differs from it.
  function automatic add_result_t fixed_point_add(input fixed_point_t a,
                                                  input fixed_point_t b);
    add_result_t r;
    r.sum      = a + b;
    r.overflow = (a[FIXED_POINT_W-1] == b[FIXED_POINT_W-1]) &&
                 (r.sum[FIXED_POINT_W-1] != a[FIXED_POINT_W-1]);
    return r;
  endfunction

  // Clamp toward the side the true sum lies on; op1's sign identifies it
  // because overflow only happens when both operands share that sign.
  function automatic fixed_point_t fixed_point_saturate(input fixed_point_t sum,
                                                        input logic         overflow,
                                                        input fixed_point_t op1);
    fixed_point_t r;
    r = sum;
    if (overflow) begin
      r = op1[FIXED_POINT_W-1] ? FIXED_POINT_MIN : FIXED_POINT_MAX;
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_point_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// grant and wraps, so the most recently served requester has lowest priority.
module fixed_point_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_grant
);

  // cand_idx[k] is the requester examined at priority position k (0 = highest).
  logic [ID_W-1:0] cand_idx [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = ID_W'((int'(last_grant) + gi + 1) % NUM_REQ);
    end
  endgenerate

  // Walk from lowest to highest priority so the highest-priority hit is
  // the last one written.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        grant              = '0;
        grant[cand_idx[k]] = 1'b1;
        grant_idx          = cand_idx[k];
        any_grant          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fixed_point_add_arbiter.sv
// Shares one fixed-point adder between NUM_REQ requesters. Round-robin
// arbitration feeds a single registered response channel carrying the owner
// ID, the raw overflow flag and an optionally saturated sum, plus a
// saturating count of overflowing adds.
module fixed_point_add_arbiter
  import fixed_point_add_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = $clog2(NUM_REQ),
  parameter int SATURATE  = 1,
  parameter int OVF_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  fixed_point_t         req_op1 [NUM_REQ],
  input  fixed_point_t         req_op2 [NUM_REQ],
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output fixed_point_t         resp_result,
  output logic                 resp_overflow,
  output logic [OVF_CNT_W-1:0] ovf_count,
  input  logic                 ovf_clear
);

  localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = '1;

  out_state_t      state;
  logic [ID_W-1:0] last_grant;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any_grant;
  logic               accept;
  logic               fire;

  fixed_point_t op1_sel;
  fixed_point_t op2_sel;
  add_result_t  add_res;
  fixed_point_t result_next;

  fixed_point_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_grant  (any_grant)
  );

  // The output register can take a new result when empty or being drained.
  assign accept = (state == OUT_EMPTY) | resp_ready;
  assign fire   = accept & any_grant;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = accept & grant[gi] & req_valid[gi];
    end
  endgenerate

  assign op1_sel     = req_op1[grant_idx];
  assign op2_sel     = req_op2[grant_idx];
  assign add_res     = fixed_point_add(op1_sel, op2_sel);
  assign result_next = (SATURATE != 0)
                     ? fixed_point_saturate(add_res.sum, add_res.overflow, op1_sel)
                     : add_res.sum;

  assign resp_valid = (state == OUT_FULL);

  // Output register FSM: load on every handshake (pass-through when draining),
  // otherwise empty once the consumer takes the held response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= OUT_EMPTY;
      last_grant    <= ID_W'(NUM_REQ - 1);
      resp_id       <= '0;
      resp_result   <= '0;
      resp_overflow <= 1'b0;
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (fire) begin
            state         <= OUT_FULL;
            last_grant    <= grant_idx;
            resp_id       <= grant_idx;
            resp_result   <= result_next;
            resp_overflow <= add_res.overflow;
          end
        end
        OUT_FULL: begin
          if (fire) begin
            last_grant    <= grant_idx;
            resp_id       <= grant_idx;
            resp_result   <= result_next;
            resp_overflow <= add_res.overflow;
          end else if (resp_ready) begin
            state <= OUT_EMPTY;
          end
        end
        default: state <= OUT_EMPTY;
      endcase
    end
  end

  // Overflow event counter: clear wins over a same-cycle overflow; sticks at max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (ovf_clear) begin
      ovf_count <= '0;
    end else if (fire && add_res.overflow && (ovf_count != OVF_CNT_MAX)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule

// File: doc/fixed_point_add_arbiter.md
Name: fixed_point_add_arbiter

Overview:
- Shares one `fixed_point_add` datapath between NUM_REQ requesters using round-robin arbitration.
- Each requester has its own valid/ready request channel. Results return on a single registered response channel with a requester ID, overflow flag and optional saturation.
- Sits between the rasteriser/shader stages and the single adder, so that adders are not replicated per stage.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- ID_W, $clog2(NUM_REQ): width of the requester ID.
- SATURATE, 1: 1 = clamp the result to FIXED_POINT_MAX/MIN on overflow; 0 = pass the wrapped sum.
- OVF_CNT_W, 16: width of the overflow event counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set per cycle.
- req_op1  in  NUM_REQ x fixed_point_t  first operand per requester.
- req_op2  in  NUM_REQ x fixed_point_t  second operand per requester.
- resp_valid  out  1  response valid.
- resp_ready  in  1  downstream accept.
- resp_id  out  ID_W  index of the requester that owns the response.
- resp_result  out  fixed_point_t  sum, wrapped or saturated.
- resp_overflow  out  1  signed overflow occurred on this add (raw, before saturation).
- ovf_count  out  OVF_CNT_W  running count of overflowing adds; saturates at all-ones.
- ovf_clear  in  1  synchronous clear of ovf_count.

Behaviour:
- Reset (async assert, sync deassert handled upstream) sets:
  - resp_valid=0, resp_id=0, resp_result=0, resp_overflow=0, ovf_count=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
- Output register states:
  - EMPTY (resp_valid=0) and FULL (resp_valid=1).
  - accept = EMPTY | resp_ready.
- Arbitration, combinational:
  - Scan req_valid starting at last_grant+1, wrapping modulo NUM_REQ. The first set bit wins.
  - req_ready[g] = accept & req_valid[g] for the winner g; all other bits are 0.
  - req_ready never asserts without the matching req_valid.
- Transfer: when req_valid[g] & req_ready[g], on the next edge:
  - load resp_result, resp_overflow, resp_id=g;
  - set resp_valid=1;
  - set last_grant=g.
- Latency is exactly 1 cycle from handshake to resp_valid. Throughput is 1 add/cycle while resp_ready=1.
- Back-pressure:
  - FULL & !resp_ready: all req_ready=0, and the response holds stable (result, id, overflow unchanged).
  - FULL & resp_ready & no request: move to EMPTY on the next edge.
  - FULL & resp_ready & request: the register reloads (pass-through, no bubble).
- Arithmetic:
  - Datapath is `fixed_point_add` on the granted operands: two's-complement wrap.
  - overflow = operand signs equal and result sign differs.
  - SATURATE=1 and overflow: result = FIXED_POINT_MAX if op1 sign is 0, else FIXED_POINT_MIN.
- Overflow counter:
  - Increments by 1 on each accepted add with overflow=1, saturating at 2^OVF_CNT_W-1.
  - ovf_clear has priority: count -> 0 that cycle. A simultaneous overflow in that same cycle is not counted.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 grants.
- Requester stability: a requester must hold its operands while valid and not ready. Dropping valid before grant is legal and loses nothing.
- Reset mid-operation: a pending response is discarded and last_grant resets. No response is emitted for a request that was accepted but not yet consumed.

Decomposition:
- fixed_point package gains:
  - FIXED_POINT_MAX (0x7FFF_FFFF) and FIXED_POINT_MIN (0x8000_FFFF is wrong; use 0x8000_0000) constants.
  - fixed_point_t is 32-bit signed.
- Sub-module fixed_point_rr_arbiter: combinational, parameter NUM_REQ. Inputs req and last_grant; outputs grant one-hot, grant_idx and any_grant. Reusable by the multiplier arbiter.
- The top instantiates fixed_point_rr_arbiter, one fixed_point_add, the saturation mux, the output register and the counter.

Test Plan:
- Single add: requester 2 sends op1=0x0001_0000, op2=0x0002_0000 with resp_ready=1. Expect req_ready[2]=1 the same cycle; next cycle resp_valid=1, id=2, result=0x0003_0000, overflow=0.
- Round-robin: all 4 requesters valid continuously after reset. Expect grant order 0,1,2,3,0, one per cycle, and resp_id following one cycle later.
- Back-pressure: resp_ready=0 for 3 cycles with requests pending. Expect all req_ready=0 and the response stable; on resp_ready=1, the next grant is issued in the same cycle.
- Saturation: op1=0x7FFF_0000, op2=0x0001_0000.
  - SATURATE=1: result=0x7FFF_FFFF, overflow=1, ovf_count=1.
  - SATURATE=0: result=0x8000_0000.
  - Also 0x8000_0000+0xFFFF_FFFF gives 0x8000_0000 (SATURATE=1).
- Counter edges:
  - Force ovf_count to 0xFFFF via 65535 overflows; a further overflow keeps it at 0xFFFF.
  - ovf_clear together with an overflow gives 0.
- Reset mid-flight: assert rst while resp_valid=1 with id=3. Expect immediate resp_valid=0 and ovf_count=0; after release, requester 0 wins first.
